fpu_op_dispatch: RTL

Front-end sequencer for the FP ALU. It accepts one operation request (opcode plus two 32-bit operands) over a valid/ready handshake and launches the selected arithmetic unit (add, sub, mul or div) with a one-cycle start pulse. It then waits for that unit's done flag, captures the unit's result, and returns it over a valid/ready response port. It is the issue side that pairs with the existing 2-bit result select: opcode encoding is identical (0 add, 1 sub, 2 mul, 3 div).

---
 rtl/fpu_op_dispatch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fpu_op_dispatch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fpu_op_dispatch                                          |
// | Description : FP ALU issue sequencer. Accepts one op, pulses the       |
// |               selected unit's start, waits for its done (with a        |
// |               timeout) and returns the captured result.                |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module fpu_op_dispatch #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      TIMEOUT     = 64,
  parameter logic [WIDTH-1:0] TIMEOUT_VAL = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       unit_start,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic [3:0]       unit_done,
  input  logic [WIDTH-1:0] add_res,
  input  logic [WIDTH-1:0] sub_res,
  input  logic [WIDTH-1:0] mul_res,
  input  logic [WIDTH-1:0] div_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic             rsp_timeout
);

  localparam int unsigned          c_cnt_w    = $clog2(TIMEOUT) + 1;
  localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_done;
  logic [WIDTH-1:0]   w_sel_res;

  // Only the launched unit's done flag matters; others are ignored.
  always_comb begin
    w_done    = unit_done[r_op];
    w_sel_res = add_res;
    case (r_op)
      2'd0:    w_sel_res = add_res;
      2'd1:    w_sel_res = sub_res;
      2'd2:    w_sel_res = mul_res;
      default: w_sel_res = div_res;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_done || (r_cnt == c_cnt_last)) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_cnt       <= '0;
      unit_a      <= '0;
      unit_b      <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            unit_a <= req_a;
            unit_b <= req_b;
          end
        end
        S_LAUNCH: r_cnt <= '0;
        S_WAIT: begin
          // A done in the final wait cycle beats the timeout.
          if (w_done) begin
            rsp_data    <= w_sel_res;
            rsp_timeout <= 1'b0;
          end else if (r_cnt == c_cnt_last) begin
            rsp_data    <= TIMEOUT_VAL;
            rsp_timeout <= 1'b1;
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && rst_n;
  assign unit_start = (r_state == S_LAUNCH) ? (4'b0001 << r_op) : 4'b0000;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_op     = r_op;

endmodule
`default_nettype wire
